score_display: RTL and testbench

//  Consumer of the 4-digit BCD score bus (score0 units .. score3 thousands) produced by the scoring logic.

---
 rtl/score_pkg.sv | 39 +++
 rtl/seg7_decode.sv | 39 +++
 rtl/score_display.sv | 160 ++++++++++++++++
 tb/tb_score_display.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// ============================================================================
// Module      : score_pkg
// Description : Shared glyph table, digit-index and BCD types for score_display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package score_pkg;

  // Segment order is {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } digit_idx_t;

  typedef logic [3:0] bcd_t;

  function automatic logic bcd_valid(input bcd_t d);
    return (d <= 4'd9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// Module      : seg7_decode
// Description : BCD digit + blank request -> active-low 7-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode
  import score_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end else begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_DASH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/score_display.sv
// ============================================================================
// Module      : score_display
// Description : 4-digit multiplexed 7-segment score display with leading-zero
//               blanking; optional high-score register (SCORE_DISPLAY_HISCORE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_display
  import score_pkg::*;
#(
  parameter int PRESCALE = 100000,
  parameter int CNT_W    = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_score0,
  input  logic [3:0] i_score1,
  input  logic [3:0] i_score2,
  input  logic [3:0] i_score3,
  input  logic       i_game_over,
  input  logic       i_show_hi,
  output logic [3:0] o_an,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic       o_new_record
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;
  digit_idx_t       r_state;
  digit_idx_t       w_state_next;
  logic [15:0]      w_live;
  logic [15:0]      w_snap_src;
  logic [15:0]      r_snap;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic             w_blank1;
  logic             w_blank2;
  logic             w_blank3;
  logic [6:0]       w_seg;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  assign w_live = {i_score3, i_score2, i_score1, i_score0};
  assign w_tick = (r_cnt == CNT_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst || w_tick) r_cnt <= '0;
    else               r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= D0;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_tick) begin
      case (r_state)
        D0:      w_state_next = D1;
        D1:      w_state_next = D2;
        D2:      w_state_next = D3;
        default: w_state_next = D0;
      endcase
    end
  end

  // The frame content is frozen at the D3->D0 tick so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst)                          r_snap <= '0;
    else if (w_tick && r_state == D3) r_snap <= w_snap_src;
  end

  // A dash (10-15) is non-zero, so it stops the blanking chain.
  assign w_blank3 = (r_snap[15:12] == 4'd0);
  assign w_blank2 = w_blank3 && (r_snap[11:8] == 4'd0);
  assign w_blank1 = w_blank2 && (r_snap[7:4] == 4'd0);

  always_comb begin
    w_digit = r_snap[3:0];
    w_blank = 1'b0;
    case (r_state)
      D1: begin w_digit = r_snap[7:4];   w_blank = w_blank1; end
      D2: begin w_digit = r_snap[11:8];  w_blank = w_blank2; end
      D3: begin w_digit = r_snap[15:12]; w_blank = w_blank3; end
      default: begin w_digit = r_snap[3:0]; w_blank = 1'b0; end
    endcase
  end

  seg7_decode u_decode (
    .i_bcd   (w_digit),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(4'b0001 << r_state);
      r_seg <= w_seg;
    end
  end

  assign o_an  = r_an;
  assign o_seg = r_seg;

`ifdef SCORE_DISPLAY_HISCORE_EN
  logic [15:0] r_hi;
  logic        r_new_record;
  logic        r_snap_hi;
  logic        r_dp;
  logic        w_live_valid;

  assign w_live_valid = bcd_valid(i_score0) && bcd_valid(i_score1) &&
                        bcd_valid(i_score2) && bcd_valid(i_score3);

  // Plain unsigned compare orders valid BCD values correctly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi         <= '0;
      r_new_record <= 1'b0;
    end else if (i_game_over) begin
      if (w_live_valid && (w_live > r_hi)) begin
        r_hi         <= w_live;
        r_new_record <= 1'b1;
      end else begin
        r_new_record <= 1'b0;
      end
    end
  end

  assign w_snap_src = i_show_hi ? r_hi : w_live;

  always_ff @(posedge clk) begin
    if (rst)                          r_snap_hi <= 1'b0;
    else if (w_tick && r_state == D3) r_snap_hi <= i_show_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) r_dp <= 1'b1;
    else     r_dp <= !((r_state == D3) && r_snap_hi);
  end

  assign o_dp         = r_dp;
  assign o_new_record = r_new_record;
`else
  logic w_unused;
  assign w_unused     = &{1'b0, i_game_over, i_show_hi};
  assign w_snap_src   = w_live;
  assign o_dp         = 1'b1;
  assign o_new_record = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_score_display.sv
// ============================================================================
// Module      : tb_score_display
// Description : Self-checking bench for score_display against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_display;

  localparam int P = 2;
`ifdef SCORE_DISPLAY_HISCORE_EN
  localparam bit HI = 1'b1;
`else
  localparam bit HI = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
  logic       go = 1'b0, sh = 1'b0;
  logic [3:0] o_an;
  logic [6:0] o_seg;
  logic       o_dp, o_new_record;

  always #5 clk = ~clk;

  score_display #(.PRESCALE(P), .CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_score0     (s0),
    .i_score1     (s1),
    .i_score2     (s2),
    .i_score3     (s3),
    .i_game_over  (go),
    .i_show_hi    (sh),
    .o_an         (o_an),
    .o_seg        (o_seg),
    .o_dp         (o_dp),
    .o_new_record (o_new_record)
  );

  int n_chk = 0, n_pass = 0;

  // Reference model: edge count since reset gives the digit slot and frame.
  int          e = 0;
  logic [15:0] m_snap = '0, m_hi = '0;
  bit          m_snap_hi = 1'b0, m_nr = 1'b0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp = 1'b1, exp_nr = 1'b0;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40; 4'd1: return 7'h79; 4'd2: return 7'h24;
      4'd3: return 7'h30; 4'd4: return 7'h19; 4'd5: return 7'h12;
      4'd6: return 7'h02; 4'd7: return 7'h78; 4'd8: return 7'h00;
      4'd9: return 7'h10; default: return 7'h3F;
    endcase
  endfunction

  // A digit is blank when it and every higher digit are zero (never the units).
  function automatic logic [6:0] model_seg(input logic [15:0] v, input int slot);
    logic [3:0] d;
    bit lead;
    d = v[slot*4 +: 4];
    lead = (slot != 0);
    for (int k = slot; k < 4; k++) if (v[k*4 +: 4] != 4'd0) lead = 1'b0;
    return lead ? 7'h7F : glyph(d);
  endfunction

  initial forever begin
    logic [15:0] live;
    logic [3:0]  one;
    int          slot;
    @(posedge clk);
    live = {s3, s2, s1, s0};
    one  = 4'b0001;
    if (rst) begin
      e = 0; m_snap = '0; m_hi = '0; m_snap_hi = 1'b0; m_nr = 1'b0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      e++;
      slot    = ((e - 1) / P) % 4;
      exp_an  = ~(one << slot);
      exp_seg = model_seg(m_snap, slot);
      exp_dp  = !(HI && slot == 3 && m_snap_hi);
      if (e % (4 * P) == 0) begin
        if (HI && sh) begin m_snap = m_hi; m_snap_hi = 1'b1; end
        else          begin m_snap = live; m_snap_hi = 1'b0; end
      end
      if (HI && go) begin
        if (s0 <= 9 && s1 <= 9 && s2 <= 9 && s3 <= 9 && live > m_hi) begin
          m_hi = live; m_nr = 1'b1;
        end else begin
          m_nr = 1'b0;
        end
      end
    end
    exp_nr = m_nr;
  end

  task automatic set_score(input logic [15:0] v);
    {s3, s2, s1, s0} = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_score(16'h0000); go = 1'b0; sh = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({o_an, o_seg, o_dp, o_new_record} !== {4'hF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL reset_values an=%b seg=%h dp=%b nr=%b want an=1111 seg=7f dp=1 nr=0",
               o_an, o_seg, o_dp, o_new_record);
    else n_pass++;
    rst = 1'b0;
    repeat (3 * 4 * P) begin
      @(negedge clk);
      n_chk++;
      if ({o_an, o_seg, o_dp, o_new_record} !== {exp_an, exp_seg, exp_dp, exp_nr})
        $display("FAIL scan_zero an=%b seg=%h dp=%b nr=%b want an=%b seg=%h dp=%b nr=%b",
                 o_an, o_seg, o_dp, o_new_record, exp_an, exp_seg, exp_dp, exp_nr);
      else n_pass++;
    end
  endtask

  task automatic test_midframe();
    set_score(16'h0305);
    repeat (2 * 4 * P) begin
      @(negedge clk);
      n_chk++;
      if ({o_an, o_seg, o_dp} !== {exp_an, exp_seg, exp_dp})
        $display("FAIL show_0305 an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 o_an, o_seg, o_dp, exp_an, exp_seg, exp_dp);
      else n_pass++;
    end
    // Change the score while the scan is in the middle of a frame.
    for (int i = 0; i < 40 && exp_an != 4'b1101; i++) @(negedge clk);
    set_score(16'h0999);
    repeat (2 * 4 * P) begin
      @(negedge clk);
      n_chk++;
      if ({o_an, o_seg, o_dp} !== {exp_an, exp_seg, exp_dp})
        $display("FAIL midframe_0999 an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 o_an, o_seg, o_dp, exp_an, exp_seg, exp_dp);
      else n_pass++;
    end
  endtask

  task automatic test_dash();
    set_score(16'hB000);
    repeat (2 * 4 * P) begin
      @(negedge clk);
      n_chk++;
      if ({o_an, o_seg, o_dp} !== {exp_an, exp_seg, exp_dp})
        $display("FAIL dash_B000 an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 o_an, o_seg, o_dp, exp_an, exp_seg, exp_dp);
      else n_pass++;
    end
  endtask

  task automatic test_hiscore();
    rst = 1'b1; go = 1'b0; sh = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    set_score(16'h0120); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n_chk++;
    if (o_new_record !== exp_nr)
      $display("FAIL record_0120 nr=%b want nr=%b", o_new_record, exp_nr);
    else n_pass++;
    repeat (3) @(negedge clk);
    set_score(16'h0050); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n_chk++;
    if (o_new_record !== exp_nr)
      $display("FAIL record_0050 nr=%b want nr=%b", o_new_record, exp_nr);
    else n_pass++;
    sh = 1'b1;
    repeat (3 * 4 * P) begin
      @(negedge clk);
      n_chk++;
      if ({o_an, o_seg, o_dp, o_new_record} !== {exp_an, exp_seg, exp_dp, exp_nr})
        $display("FAIL show_hi an=%b seg=%h dp=%b nr=%b want an=%b seg=%h dp=%b nr=%b",
                 o_an, o_seg, o_dp, o_new_record, exp_an, exp_seg, exp_dp, exp_nr);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      n_chk++;
      if ({o_an, o_seg, o_dp, o_new_record} !== {exp_an, exp_seg, exp_dp, exp_nr})
        $display("FAIL random c=%0d an=%b seg=%h dp=%b nr=%b want an=%b seg=%h dp=%b nr=%b",
                 c, o_an, o_seg, o_dp, o_new_record, exp_an, exp_seg, exp_dp, exp_nr);
      else n_pass++;
      go = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        s0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        s1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
        s2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
        s3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 10));
      end
      if ($urandom_range(0, 9) == 0) go = 1'b1;
      if ($urandom_range(0, 19) == 0) sh = ~sh;
    end
    go = 1'b0;
  endtask

  task automatic test_rst_mid();
    set_score(16'h0777); sh = 1'b1;
    for (int i = 0; i < 40 && exp_an != 4'b1011; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({o_an, o_seg, o_dp, o_new_record} !== {4'hF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL rst_mid an=%b seg=%h dp=%b nr=%b want an=1111 seg=7f dp=1 nr=0",
               o_an, o_seg, o_dp, o_new_record);
    else n_pass++;
    rst = 1'b0;
    repeat (3 * 4 * P) begin
      @(negedge clk);
      n_chk++;
      if ({o_an, o_seg, o_dp, o_new_record} !== {exp_an, exp_seg, exp_dp, exp_nr})
        $display("FAIL restart an=%b seg=%h dp=%b nr=%b want an=%b seg=%h dp=%b nr=%b",
                 o_an, o_seg, o_dp, o_new_record, exp_an, exp_seg, exp_dp, exp_nr);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_midframe();
    test_dash();
    test_hiscore();
    test_random();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
